// File: rtl/stim_replay_misr.sv
// stim_replay_misr: replays stored stimulus vectors into a DUT and
// compacts the DUT response into a MISR signature.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   load_en/addr/data  vector memory write port (honoured in IDLE/DONE)
//   start              begin a replay run (ignored while busy)
//   dut_y              DUT output bus, folded into the MISR on each capture
//   dut_in             registered drive to the DUT input bus
//   busy, done         run in progress / run complete (sig valid)
//   cur_idx            0 = zero phase, i+1 = stored vector i
//   sig                MISR signature
// Optional feature macro STIM_REPLAY_GOLDEN_CMP_EN adds golden_sig input
// and mismatch output (registered compare on entry to DONE).

module stim_replay_misr #(
    parameter int unsigned IN_W  = 256,
    parameter int unsigned OUT_W = 151,
    parameter int unsigned DEPTH = 21,
    parameter int unsigned HOLD  = 1,
    parameter int unsigned SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
    localparam int unsigned AW =
        (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned IW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [IN_W-1:0]  load_data,
    input  logic             start,
    input  logic [OUT_W-1:0] dut_y,
`ifdef STIM_REPLAY_GOLDEN_CMP_EN
    input  logic [SIG_W-1:0] golden_sig,
    output logic             mismatch,
`endif
    output logic [IN_W-1:0]  dut_in,
    output logic             busy,
    output logic             done,
    output logic [IW-1:0]    cur_idx,
    output logic [SIG_W-1:0] sig
);

    localparam int unsigned HW =
        (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned NS =
        (OUT_W + SIG_W - 1) / SIG_W;
    localparam int unsigned AW1 = AW + 1;
    localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);
    localparam logic [IW-1:0] ILAST = IW'(DEPTH);
    localparam logic [AW:0]   ALIM  = AW1'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ZERO,
        RUN,
        DONE
    } state_t;

    state_t state;

    logic [IN_W-1:0]     mem [DEPTH];
    logic [HW-1:0]       hcnt;
    logic [NS*SIG_W-1:0] ypad;
    logic [SIG_W-1:0]    yfold;
    logic [SIG_W-1:0]    sig_next;
    logic                addr_ok;
    logic                last_hold;
    logic                last_vec;

    assign addr_ok   = {1'b0, load_addr} < ALIM;
    assign last_hold = (hcnt == HLAST);
    assign last_vec  = (cur_idx == ILAST);

    // Fold the output bus into SIG_W bits, top slice zero-padded.
    always_comb begin
        ypad = '0;
        ypad[OUT_W-1:0] = dut_y;
        yfold = '0;
        for (int i = 0; i < int'(NS); i++) begin
            yfold = yfold ^ ypad[i*SIG_W +: SIG_W];
        end
        sig_next = (sig << 1)
                 ^ (sig[SIG_W-1] ? POLY : '0)
                 ^ yfold;
    end

    // Vector memory is deliberately not reset so a run can be
    // repeated after rst without reloading.
    always_ff @(posedge clk) begin
        if (load_en && !busy && addr_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dut_in  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cur_idx <= '0;
            sig     <= '0;
            hcnt    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= ZERO;
                        dut_in  <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        cur_idx <= '0;
                        sig     <= '0;
                        hcnt    <= '0;
                    end
                end
                ZERO, RUN: begin
                    if (last_hold) begin
                        // Capture on the edge that advances dut_in.
                        sig  <= sig_next;
                        hcnt <= '0;
                        if (last_vec) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            dut_in  <= mem[cur_idx[AW-1:0]];
                            cur_idx <= cur_idx + 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STIM_REPLAY_GOLDEN_CMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (!busy && start) begin
            mismatch <= 1'b0;
        end else if (busy && last_hold && last_vec) begin
            mismatch <= (sig_next != golden_sig);
        end
    end
`endif

endmodule

// File: tb/tb_stim_replay_misr.sv
// tb_stim_replay_misr: directed bench for stim_replay_misr.
// Three instances: D4/H1, D2/H1, D4/H3, all 8-bit with loopback.

module tb_stim_replay_misr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] ld_en;
    logic [2:0] st;
    logic [1:0] la;
    logic [7:0] ld;

    logic [7:0] din [3];
    logic [7:0] sg  [3];
    logic [2:0] bz;
    logic [2:0] dn;
    logic [2:0] ci0;
    logic [1:0] ci1;
    logic [2:0] ci2;

`ifdef STIM_REPLAY_GOLDEN_CMP_EN
    logic [7:0] gs0;
    logic [2:0] mm;
`endif

    int total = 0;
    int bad   = 0;

    stim_replay_misr #(
        .IN_W(8), .OUT_W(8), .DEPTH(4), .HOLD(1),
        .SIG_W(8), .POLY(8'h07)
    ) u0 (
        .clk(clk), .rst(rst),
        .load_en(ld_en[0]), .load_addr(la),
        .load_data(ld), .start(st[0]),
        .dut_y(din[0]),
`ifdef STIM_REPLAY_GOLDEN_CMP_EN
        .golden_sig(gs0), .mismatch(mm[0]),
`endif
        .dut_in(din[0]), .busy(bz[0]),
        .done(dn[0]), .cur_idx(ci0), .sig(sg[0])
    );

    stim_replay_misr #(
        .IN_W(8), .OUT_W(8), .DEPTH(2), .HOLD(1),
        .SIG_W(8), .POLY(8'h07)
    ) u1 (
        .clk(clk), .rst(rst),
        .load_en(ld_en[1]), .load_addr(la[0]),
        .load_data(ld), .start(st[1]),
        .dut_y(din[1]),
`ifdef STIM_REPLAY_GOLDEN_CMP_EN
        .golden_sig(8'h00), .mismatch(mm[1]),
`endif
        .dut_in(din[1]), .busy(bz[1]),
        .done(dn[1]), .cur_idx(ci1), .sig(sg[1])
    );

    stim_replay_misr #(
        .IN_W(8), .OUT_W(8), .DEPTH(4), .HOLD(3),
        .SIG_W(8), .POLY(8'h07)
    ) u2 (
        .clk(clk), .rst(rst),
        .load_en(ld_en[2]), .load_addr(la),
        .load_data(ld), .start(st[2]),
        .dut_y(din[2]),
`ifdef STIM_REPLAY_GOLDEN_CMP_EN
        .golden_sig(8'h00), .mismatch(mm[2]),
`endif
        .dut_in(din[2]), .busy(bz[2]),
        .done(dn[2]), .cur_idx(ci2), .sig(sg[2])
    );

    task automatic do_load(input logic [2:0] m,
                           input logic [1:0] a,
                           input logic [7:0] d);
        @(negedge clk);
        ld_en = m; la = a; ld = d;
        @(negedge clk);
        ld_en = '0;
    endtask

    // Pulse start, then count busy cycles (bounded).
    task automatic run(input int w, output int nb);
        @(negedge clk);
        st[w] = 1'b1;
        @(negedge clk);
        st[w] = 1'b0;
        nb = 0;
        while (bz[w] && nb < 60) begin
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ld_en = '0; st = '0;
        la = '0; ld = '0;
        repeat (2) @(negedge clk);
        total++;
        if (din[0] !== 8'h00) begin
            bad++;
            $display("FAIL rst_dut_in got %h want 00", din[0]);
        end
        total++;
        if (bz[0] !== 1'b0 || dn[0] !== 1'b0) begin
            bad++;
            $display("FAIL rst_flags busy=%b done=%b want 0 0",
                     bz[0], dn[0]);
        end
        total++;
        if (ci0 !== 3'd0 || sg[0] !== 8'h00) begin
            bad++;
            $display("FAIL rst_idx_sig got %0d %h want 0 00",
                     ci0, sg[0]);
        end
`ifdef STIM_REPLAY_GOLDEN_CMP_EN
        total++;
        if (mm[0] !== 1'b0) begin
            bad++;
            $display("FAIL rst_mismatch got %b want 0", mm[0]);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] ev [5] = '{8'h00, 8'h01, 8'h03,
                               8'h07, 8'h0F};
        int n;
        do_load(3'b101, 2'd0, 8'h01);
        do_load(3'b101, 2'd1, 8'h03);
        do_load(3'b101, 2'd2, 8'h07);
        do_load(3'b101, 2'd3, 8'h0F);
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        n = 0;
        while (bz[0] && n < 20) begin
            if (n < 5) begin
                total++;
                if (din[0] !== ev[n] || ci0 !== 3'(n)) begin
                    bad++;
                    $display("FAIL basic_seq[%0d] got %h/%0d want %h/%0d",
                             n, din[0], ci0, ev[n], n);
                end
            end
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== 5) begin
            bad++;
            $display("FAIL basic_busy_len got %0d want 5", n);
        end
        total++;
        if (dn[0] !== 1'b1 || sg[0] !== 8'h05) begin
            bad++;
            $display("FAIL basic_sig got done=%b sig=%h want 1 05",
                     dn[0], sg[0]);
        end
        total++;
        if (din[0] !== 8'h0F) begin
            bad++;
            $display("FAIL basic_hold_last got %h want 0F", din[0]);
        end
        repeat (3) @(negedge clk);
        total++;
        if (dn[0] !== 1'b1 || sg[0] !== 8'h05) begin
            bad++;
            $display("FAIL basic_stable got done=%b sig=%h want 1 05",
                     dn[0], sg[0]);
        end
    endtask

    task automatic test_msb_and_load_start;
        int n;
        do_load(3'b010, 2'd1, 8'h00);
        // Write vector 0 on the same edge as start.
        @(negedge clk);
        ld_en = 3'b010; la = 2'd0; ld = 8'h80;
        st[1] = 1'b1;
        @(negedge clk);
        ld_en = '0; st[1] = 1'b0;
        n = 0;
        while (bz[1] && n < 20) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL msb_busy_len got %0d want 3", n);
        end
        total++;
        if (dn[1] !== 1'b1 || sg[1] !== 8'h07) begin
            bad++;
            $display("FAIL msb_sig got done=%b sig=%h want 1 07",
                     dn[1], sg[1]);
        end
    endtask

    task automatic test_hold;
        logic [7:0] ev [5] = '{8'h00, 8'h01, 8'h03,
                               8'h07, 8'h0F};
        int n;
        @(negedge clk);
        st[2] = 1'b1;
        @(negedge clk);
        st[2] = 1'b0;
        n = 0;
        while (bz[2] && n < 40) begin
            if (n < 15) begin
                total++;
                if (ci2 !== 3'(n / 3) || din[2] !== ev[n / 3]) begin
                    bad++;
                    $display("FAIL hold_seq[%0d] got %0d/%h want %0d/%h",
                             n, ci2, din[2], n / 3, ev[n / 3]);
                end
            end
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== 15) begin
            bad++;
            $display("FAIL hold_busy_len got %0d want 15", n);
        end
        total++;
        if (dn[2] !== 1'b1 || sg[2] !== 8'h05) begin
            bad++;
            $display("FAIL hold_sig got done=%b sig=%h want 1 05",
                     dn[2], sg[2]);
        end
    endtask

    task automatic test_rst_mid;
        int n;
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        n = 0;
        while (ci0 != 3'd3 && n < 10) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (ci0 !== 3'd3 || din[0] !== 8'h07) begin
            bad++;
            $display("FAIL rstmid_reach got %0d/%h want 3/07",
                     ci0, din[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (din[0] !== 8'h00 || sg[0] !== 8'h00 || bz[0] !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_clear got %h %h %b want 00 00 0",
                     din[0], sg[0], bz[0]);
        end
        run(0, n);
        total++;
        if (n !== 5 || sg[0] !== 8'h05) begin
            bad++;
            $display("FAIL rstmid_rerun got len=%0d sig=%h want 5 05",
                     n, sg[0]);
        end
    endtask

    task automatic test_busy_ignore;
        int n;
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        total++;
        if (bz[0] !== 1'b1 || dn[0] !== 1'b0) begin
            bad++;
            $display("FAIL restart_flags got busy=%b done=%b want 1 0",
                     bz[0], dn[0]);
        end
        @(negedge clk);
        st[0] = 1'b1;
        ld_en = 3'b001; la = 2'd1; ld = 8'hFF;
        @(negedge clk);
        st[0] = 1'b0; ld_en = '0;
        n = 2;
        while (bz[0] && n < 20) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== 5 || sg[0] !== 8'h05) begin
            bad++;
            $display("FAIL busy_ignore got len=%0d sig=%h want 5 05",
                     n, sg[0]);
        end
        run(0, n);
        total++;
        if (n !== 5 || sg[0] !== 8'h05) begin
            bad++;
            $display("FAIL done_rerun got len=%0d sig=%h want 5 05",
                     n, sg[0]);
        end
    endtask

`ifdef STIM_REPLAY_GOLDEN_CMP_EN
    task automatic test_golden;
        int n;
        gs0 = 8'h05;
        run(0, n);
        total++;
        if (mm[0] !== 1'b0) begin
            bad++;
            $display("FAIL golden_match got %b want 0", mm[0]);
        end
        gs0 = 8'h06;
        run(0, n);
        total++;
        if (mm[0] !== 1'b1) begin
            bad++;
            $display("FAIL golden_diff got %b want 1", mm[0]);
        end
    endtask
`endif

    initial begin
`ifdef STIM_REPLAY_GOLDEN_CMP_EN
        gs0 = 8'h05;
`endif
        test_reset;
        test_basic;
        test_msb_and_load_start;
        test_hold;
        test_rst_mid;
        test_busy_ignore;
`ifdef STIM_REPLAY_GOLDEN_CMP_EN
        test_golden;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stim_replay_misr.md
Name: stim_replay_misr

Overview:
- Synthesizable stimulus replayer and response compactor for differential netlist checking.
- Holds DEPTH wide stimulus vectors in internal memory and applies them to a DUT's concatenated input bus, each for HOLD clocks, preceded by one all-zero vector.
- Folds the DUT's output bus into a MISR signature. Two netlists are compared by signature rather than by per-cycle text dumps.
- Sits beside the DUT (`top`) in a synthesized wrapper; DUT and block share one clock.

Parameters:
- IN_W, 256, width of the DUT input bus (`dut_in`) and of each stored vector
- OUT_W, 151, width of the DUT output bus `dut_y`
- DEPTH, 21, number of stored stimulus vectors (>=1)
- HOLD, 1, clocks each vector is held (>=1)
- SIG_W, 32, MISR width
- POLY, 32'h04C11DB7, MISR feedback polynomial (SIG_W bits)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- load_en  in  1  write strobe for vector memory
- load_addr  in  clog2(DEPTH)  vector index to write
- load_data  in  IN_W  vector value
- start  in  1  begin a replay run
- dut_y  in  OUT_W  DUT output bus, sampled by this block
- dut_in  out  IN_W  registered drive to the DUT input bus
- busy  out  1  run in progress
- done  out  1  run complete; sig valid
- cur_idx  out  clog2(DEPTH+1)  0 = zero phase, i+1 = stored vector i
- sig  out  SIG_W  MISR signature

Behaviour:
- One clock domain; synchronous active-high reset.
- Reset values: dut_in=0, busy=0, done=0, cur_idx=0, sig=0, state=IDLE, hold counter=0. Vector memory is not reset.
- States: IDLE, ZERO, RUN, DONE.
- IDLE:
  - start=1 -> ZERO at the next edge; sig cleared to 0; busy=1; dut_in=0; cur_idx=0.
- ZERO:
  - dut_in=0 for HOLD clocks.
  - On the last hold clock, dut_y is captured into the MISR.
  - The state then moves to RUN with dut_in=mem[0] and cur_idx=1.
- RUN:
  - Vector i is driven for HOLD clocks.
  - dut_y is captured on the edge ending the last hold clock, i.e. the same edge on which dut_in advances.
  - After vector DEPTH-1 is captured, the state moves to DONE: busy=0, done=1, dut_in holds the last vector.
- DONE:
  - done stays 1 and sig stays stable until start or rst.
  - start=1 restarts exactly as from IDLE; done drops on that edge.
- Run length:
  - busy is high for exactly (DEPTH+1)*HOLD clocks.
  - DEPTH+1 captures are made in total.
- MISR update on each capture:
  - sig_next = (sig << 1) ^ (sig[SIG_W-1] ? POLY : 0) ^ fold(dut_y).
  - fold(dut_y) = XOR of consecutive SIG_W-bit slices of dut_y, LSB-aligned; the top slice is zero-padded.
- start while busy: ignored.
- load_en:
  - Writes mem[load_addr] only in IDLE or DONE; ignored while busy.
  - load_addr >= DEPTH is ignored.
- rst mid-run: immediate return to reset values; memory contents retained.
- load_en and start in the same cycle (IDLE/DONE): the write happens first and is visible to the run.

Optional Feature:
- Macro: STIM_REPLAY_GOLDEN_CMP_EN.
- Defined:
  - Adds input golden_sig (SIG_W) and output mismatch (1).
  - mismatch is a registered compare of sig against golden_sig, updated on entry to DONE and held until the next start or rst. Reset value 0.
  - It is 1 iff the signatures differ.
- Undefined:
  - Ports absent; no compare logic.

Test Plan:
- Common bench setup: IN_W=OUT_W=8, SIG_W=8, POLY=8'h07, dut_y looped back to dut_in, unless a line says otherwise.
- DEPTH=4, HOLD=1, load 01,03,07,0F, pulse start:
  - dut_in sequence 00,01,03,07,0F.
  - busy high 5 clocks.
  - done=1, sig=8'h05.
- DEPTH=2, HOLD=1, load 80,00, start -> sig=8'h07 (exercises MSB feedback).
- DEPTH=4, HOLD=3 -> each vector held 3 clocks; busy high exactly 15 clocks; cur_idx steps 0..4; sig=8'h05 unchanged.
- Assert rst during the vector-2 phase of the first test:
  - Next edge: dut_in=0, sig=0, busy=0.
  - Re-start without reloading -> sig=8'h05 again (memory retained).
- Pulse start and load_en while busy:
  - Both ignored: run completes with sig=8'h05, memory unchanged.
  - start in DONE reruns and gives the same sig.
- With STIM_REPLAY_GOLDEN_CMP_EN:
  - golden_sig=8'h05 -> mismatch=0.
  - golden_sig=8'h06 -> mismatch=1 at done.
